// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller: FSM state encoding,
// exception cause codes and the default exception vector.
// Optional feature macro used by this block: EXEC_CTRL_BREAKPOINT_EN.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_EXC  = 2'd3
  } state_t;

  localparam logic [2:0] CAUSE_OVERFLOW  = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL   = 3'd2;
  localparam logic [2:0] CAUSE_ALU_UNDEF = 3'd3;
  localparam logic [2:0] CAUSE_RESERVED  = 3'd7;

  localparam logic [7:0] EXC_VECTOR_DFLT = 8'h80;

endpackage

// File: rtl/exec_retire_cnt.sv
// Saturating retired-instruction counter with synchronous clear.
// Latency: count visible one cycle after the increment/clear request.
// No backpressure; clear wins over increment, the count sticks at all-ones.
module exec_retire_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count commits, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/exec_ctrl.sv
// Execution controller: run/step/halt FSM, PC write mux, EPC/cause capture.
// Latency: pc_we/pc_next/commit are combinational; state, EPC, cause, count registered.
// No backpressure; control pulses outside HALT/RUN are dropped (halt in EXC returns to HALT).
// Optional breakpoint support is enabled with the macro EXEC_CTRL_BREAKPOINT_EN.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter int              CNT_W      = 16,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DFLT)
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             CTRL_run,
  input  logic             CTRL_step,
  input  logic             CTRL_halt,
  input  logic             CTRL_load,
  input  logic [PC_W-1:0]  CTRL_load_val,
  input  logic [PC_W-1:0]  CPU_pc,
  input  logic [PC_W-1:0]  CPU_pc_seq,
  input  logic             CPU_exception,
  input  logic [2:0]       CPU_cause,
  input  logic             CPU_eret,
`ifdef EXEC_CTRL_BREAKPOINT_EN
  input  logic [PC_W-1:0]  BP_addr,
  input  logic             BP_valid,
  output logic             CTRL_bp_hit,
`endif
  output logic             CTRL_pc_we,
  output logic [PC_W-1:0]  CTRL_pc_next,
  output logic             CTRL_commit,
  output logic [PC_W-1:0]  CTRL_epc,
  output logic [2:0]       CTRL_cause,
  output logic [1:0]       CTRL_state,
  output logic [CNT_W-1:0] CTRL_retired
);

  state_t          r_state;
  state_t          r_ret_mode;
  logic [PC_W-1:0] r_epc;
  logic [2:0]      r_cause;

  state_t          w_state_nxt;
  logic            w_pc_we;
  logic [PC_W-1:0] w_pc_next;
  logic            w_commit;
  logic            w_exc_take;
  logic            w_bp_match;
  logic            w_load_clr;

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic r_bp_hit;
  assign w_bp_match = BP_valid && (CPU_pc == BP_addr);
`else
  assign w_bp_match = 1'b0;
`endif

  // Next-state and PC-write decode; reset forces PC to zero with nothing committed.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_we     = 1'b0;
    w_pc_next   = CPU_pc_seq;
    w_commit    = 1'b0;
    w_exc_take  = 1'b0;
    if (SYS_reset) begin
      w_pc_we     = 1'b1;
      w_pc_next   = '0;
      w_state_nxt = ST_HALT;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (CTRL_load) begin
            w_pc_we   = 1'b1;
            w_pc_next = CTRL_load_val;
          end else if (CTRL_run) begin
            w_state_nxt = ST_RUN;
          end else if (CTRL_step) begin
            w_state_nxt = ST_STEP;
          end
        end
        ST_RUN, ST_STEP: begin
          // Breakpoints and halt only stop free-run; a step always makes progress.
          if ((r_state == ST_RUN) && (w_bp_match || CTRL_halt)) begin
            w_state_nxt = ST_HALT;
          end else if (CPU_exception) begin
            w_exc_take  = 1'b1;
            w_state_nxt = ST_EXC;
          end else begin
            w_commit    = 1'b1;
            w_pc_we     = 1'b1;
            w_pc_next   = CPU_eret ? r_epc : CPU_pc_seq;
            w_state_nxt = (r_state == ST_STEP) ? ST_HALT : ST_RUN;
          end
        end
        default: begin
          w_pc_we     = 1'b1;
          w_pc_next   = EXC_VECTOR;
          w_state_nxt = CTRL_halt ? ST_HALT : r_ret_mode;
        end
      endcase
    end
  end

  // FSM state plus exception bookkeeping; a fault inside the handler simply overwrites EPC/cause.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_state    <= ST_HALT;
      r_ret_mode <= ST_HALT;
      r_epc      <= '0;
      r_cause    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exc_take) begin
        r_epc      <= CPU_pc;
        r_cause    <= CPU_cause;
        r_ret_mode <= (r_state == ST_RUN) ? ST_RUN : ST_HALT;
      end else if ((r_state == ST_EXC) && CTRL_halt) begin
        r_ret_mode <= ST_HALT;
      end
    end
  end

`ifdef EXEC_CTRL_BREAKPOINT_EN
  // Sticky breakpoint flag, cleared once the user acts on the halted core.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_bp_hit <= 1'b0;
    end else if ((r_state == ST_RUN) && w_bp_match) begin
      r_bp_hit <= 1'b1;
    end else if ((r_state == ST_HALT) && (CTRL_run || CTRL_step || CTRL_load)) begin
      r_bp_hit <= 1'b0;
    end
  end

  assign CTRL_bp_hit = r_bp_hit;
`endif

  assign w_load_clr = (r_state == ST_HALT) && CTRL_load;

  exec_retire_cnt #(
    .W (CNT_W)
  ) u_retire_cnt (
    .i_clk (SYS_clk),
    .i_rst (SYS_reset),
    .i_clr (w_load_clr),
    .i_inc (w_commit),
    .o_cnt (CTRL_retired)
  );

  assign CTRL_pc_we   = w_pc_we;
  assign CTRL_pc_next = w_pc_next;
  assign CTRL_commit  = w_commit;
  assign CTRL_epc     = r_epc;
  assign CTRL_cause   = r_cause;
  assign CTRL_state   = r_state;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: models the PC register around the DUT and
// checks commit gating, PC sequencing, exception entry/return and counting.
module tb_exec_ctrl;

  localparam int PC_W  = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             SYS_reset;
  logic             CTRL_run;
  logic             CTRL_step;
  logic             CTRL_halt;
  logic             CTRL_load;
  logic [PC_W-1:0]  CTRL_load_val;
  logic [PC_W-1:0]  CPU_pc;
  logic [PC_W-1:0]  CPU_pc_seq;
  logic             CPU_exception;
  logic [2:0]       CPU_cause;
  logic             CPU_eret;
  logic             CTRL_pc_we;
  logic [PC_W-1:0]  CTRL_pc_next;
  logic             CTRL_commit;
  logic [PC_W-1:0]  CTRL_epc;
  logic [2:0]       CTRL_cause;
  logic [1:0]       CTRL_state;
  logic [CNT_W-1:0] CTRL_retired;
`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic [PC_W-1:0]  BP_addr;
  logic             BP_valid;
  logic             CTRL_bp_hit;
`endif

  int n_chk         = 0;
  int n_err         = 0;
  int n_commit      = 0;
  int n_halt_commit = 0;
  int c0;

  exec_ctrl #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .SYS_clk       (clk),
    .SYS_reset     (SYS_reset),
    .CTRL_run      (CTRL_run),
    .CTRL_step     (CTRL_step),
    .CTRL_halt     (CTRL_halt),
    .CTRL_load     (CTRL_load),
    .CTRL_load_val (CTRL_load_val),
    .CPU_pc        (CPU_pc),
    .CPU_pc_seq    (CPU_pc_seq),
    .CPU_exception (CPU_exception),
    .CPU_cause     (CPU_cause),
    .CPU_eret      (CPU_eret),
`ifdef EXEC_CTRL_BREAKPOINT_EN
    .BP_addr       (BP_addr),
    .BP_valid      (BP_valid),
    .CTRL_bp_hit   (CTRL_bp_hit),
`endif
    .CTRL_pc_we    (CTRL_pc_we),
    .CTRL_pc_next  (CTRL_pc_next),
    .CTRL_commit   (CTRL_commit),
    .CTRL_epc      (CTRL_epc),
    .CTRL_cause    (CTRL_cause),
    .CTRL_state    (CTRL_state),
    .CTRL_retired  (CTRL_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample the PC-write request, apply it to the PC model after the edge,
  // then drop all single-cycle pulses.
  task automatic tick();
    logic            we;
    logic [PC_W-1:0] nx;
    #1;
    we = CTRL_pc_we;
    nx = CTRL_pc_next;
    if (CTRL_commit) n_commit++;
    if (CTRL_commit && (CTRL_state == 2'd0)) n_halt_commit++;
    @(posedge clk);
    #1;
    if (we) CPU_pc = nx;
    CPU_pc_seq    = CPU_pc + 8'd4;
    CTRL_run      = 1'b0;
    CTRL_step     = 1'b0;
    CTRL_halt     = 1'b0;
    CTRL_load     = 1'b0;
    CPU_exception = 1'b0;
    CPU_eret      = 1'b0;
  endtask

  initial begin
    SYS_reset     = 1'b1;
    CTRL_run      = 1'b0;
    CTRL_step     = 1'b0;
    CTRL_halt     = 1'b0;
    CTRL_load     = 1'b0;
    CTRL_load_val = '0;
    CPU_pc        = 8'h5A;
    CPU_pc_seq    = 8'h5E;
    CPU_exception = 1'b0;
    CPU_cause     = 3'd0;
    CPU_eret      = 1'b0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
    BP_addr       = '0;
    BP_valid      = 1'b0;
`endif
    @(posedge clk);
    #1;

    // Reset cycle: PC forced to zero, nothing committed.
    check("rst_pc_we", CTRL_pc_we, 1);
    check("rst_pc_next", CTRL_pc_next, 8'h00);
    check("rst_commit", CTRL_commit, 0);
    tick();
    check("rst_state", CTRL_state, 0);
    check("rst_epc", CTRL_epc, 0);
    check("rst_cause", CTRL_cause, 0);
    check("rst_retired", CTRL_retired, 0);
    check("rst_pc", CPU_pc, 8'h00);
    SYS_reset = 1'b0;

    // Load 0x10 then free-run three instructions.
    CTRL_load = 1'b1; CTRL_load_val = 8'h10;
    #1;
    check("load_pc_next", CTRL_pc_next, 8'h10);
    tick();
    check("load_pc", CPU_pc, 8'h10);
    CTRL_run = 1'b1;
    tick();
    check("run_state", CTRL_state, 1);
    check("run_pc_hold", CPU_pc, 8'h10);
    #1;
    check("run_commit", CTRL_commit, 1);
    tick();
    check("run_pc1", CPU_pc, 8'h14);
    tick();
    check("run_pc2", CPU_pc, 8'h18);
    tick();
    check("run_pc3", CPU_pc, 8'h1C);
    check("run_retired", CTRL_retired, 3);
    CTRL_halt = 1'b1;
    #1;
    check("halt_commit", CTRL_commit, 0);
    check("halt_pc_we", CTRL_pc_we, 0);
    tick();
    check("halt_state", CTRL_state, 0);
    check("halt_pc", CPU_pc, 8'h1C);

    // Two single steps from 0x20.
    CTRL_load = 1'b1; CTRL_load_val = 8'h20;
    tick();
    c0 = n_commit;
    CTRL_step = 1'b1;
    tick();
    check("step1_state", CTRL_state, 2);
    tick();
    check("step1_pc", CPU_pc, 8'h24);
    check("step1_back_halt", CTRL_state, 0);
    tick();
    check("step_idle_pc", CPU_pc, 8'h24);
    CTRL_step = 1'b1;
    tick();
    tick();
    check("step2_pc", CPU_pc, 8'h28);
    check("step2_state", CTRL_state, 0);
    check("step_commits", n_commit - c0, 2);
    check("step_retired", CTRL_retired, 2);

    // Exception in RUN at 0x34.
    CTRL_load = 1'b1; CTRL_load_val = 8'h34;
    tick();
    CTRL_run = 1'b1;
    tick();
    CPU_exception = 1'b1; CPU_cause = 3'd1;
    #1;
    check("exc_commit", CTRL_commit, 0);
    check("exc_pc_we", CTRL_pc_we, 0);
    tick();
    check("exc_state", CTRL_state, 3);
    check("exc_epc", CTRL_epc, 8'h34);
    check("exc_cause", CTRL_cause, 1);
    #1;
    check("exc_vec_next", CTRL_pc_next, 8'h80);
    check("exc_vec_we", CTRL_pc_we, 1);
    check("exc_vec_commit", CTRL_commit, 0);
    tick();
    check("exc_handler_pc", CPU_pc, 8'h80);
    check("exc_ret_run", CTRL_state, 1);
    check("exc_retired", CTRL_retired, 0);

    // Handler: one instruction, then eret, then eret with a simultaneous fault.
    tick();
    check("hdl_pc", CPU_pc, 8'h84);
    CPU_eret = 1'b1;
    #1;
    check("eret_pc_next", CTRL_pc_next, 8'h34);
    check("eret_commit", CTRL_commit, 1);
    CPU_exception = 1'b1; CPU_cause = 3'd2;
    #1;
    check("eret_exc_commit", CTRL_commit, 0);
    check("eret_exc_pc_we", CTRL_pc_we, 0);
    tick();
    check("eret_exc_state", CTRL_state, 3);
    check("eret_exc_epc", CTRL_epc, 8'h84);
    check("eret_exc_cause", CTRL_cause, 2);
    tick();
    check("eret_exc_vec", CPU_pc, 8'h80);
    check("eret_exc_retired", CTRL_retired, 1);

    // Halt and load together in RUN: load ignored; load next cycle applies.
    CTRL_halt = 1'b1; CTRL_load = 1'b1; CTRL_load_val = 8'hAA;
    tick();
    check("hl_state", CTRL_state, 0);
    check("hl_pc", CPU_pc, 8'h80);
    check("hl_retired", CTRL_retired, 1);
    CTRL_load = 1'b1; CTRL_load_val = 8'h40;
    tick();
    check("hl_load_pc", CPU_pc, 8'h40);
    check("hl_load_retired", CTRL_retired, 0);

    // Halt pressed during EXC returns to HALT instead of RUN.
    CTRL_run = 1'b1;
    tick();
    CPU_exception = 1'b1; CPU_cause = 3'd3;
    tick();
    CTRL_halt = 1'b1;
    tick();
    check("exch_state", CTRL_state, 0);
    check("exch_pc", CPU_pc, 8'h80);
    check("exch_cause", CTRL_cause, 3);
    check("exch_epc", CTRL_epc, 8'h40);

    // Retired counter saturates at all-ones.
    CTRL_run = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("sat_retired", CTRL_retired, 4'hF);
    CTRL_halt = 1'b1;
    tick();
    check("sat_halt_state", CTRL_state, 0);

`ifdef EXEC_CTRL_BREAKPOINT_EN
    // Breakpoint at 0x0C while running from 0.
    CTRL_load = 1'b1; CTRL_load_val = 8'h00;
    tick();
    BP_addr = 8'h0C; BP_valid = 1'b1;
    CTRL_run = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("bp_pc_at", CPU_pc, 8'h0C);
    #1;
    check("bp_commit", CTRL_commit, 0);
    check("bp_pc_we", CTRL_pc_we, 0);
    tick();
    check("bp_state", CTRL_state, 0);
    check("bp_hit", CTRL_bp_hit, 1);
    check("bp_retired", CTRL_retired, 3);
    check("bp_pc", CPU_pc, 8'h0C);
    CTRL_step = 1'b1;
    tick();
    check("bp_step_clear", CTRL_bp_hit, 0);
    tick();
    check("bp_step_pc", CPU_pc, 8'h10);
    check("bp_step_state", CTRL_state, 0);
    BP_valid = 1'b0;
`endif

    check("halt_never_commits", n_halt_commit, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
